// File: rtl/ripple_count_sampler.sv
// Ripple-counter sampler: 2-flop sync, stability filter, pulses, snapshot FSM.
// Optional WRAP_EXT_EN adds a wrap-extension counter in snap_data's upper bits.
module ripple_count_sampler #(
  parameter int N     = 4,
  parameter int EXT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       cnt_in,
  input  logic [N-1:0]       cmp_val,
  input  logic               snap_req,
  input  logic               snap_ready,
  output logic               snap_valid,
  output logic [EXT_W+N-1:0] snap_data,
  output logic               wrap_pulse,
  output logic               match_pulse
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]     s1, s2, s3;
  logic [N-1:0]     acc, acc_nxt;
  logic [EXT_W-1:0] ext_nxt;
  logic             load;
  logic             wrap_hit;
  logic             match_hit;
  logic             cap;

  // Only a value seen on two consecutive samples is trusted.
  assign load      = (s2 == s3);
  assign wrap_hit  = load && (s2 < acc);
  assign match_hit = load && (s2 == cmp_val) && (acc != cmp_val);
  assign acc_nxt   = load ? s2 : acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      acc         <= '0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      s1          <= cnt_in;
      s2          <= s1;
      s3          <= s2;
      acc         <= acc_nxt;
      wrap_pulse  <= wrap_hit;
      match_pulse <= match_hit;
    end
  end

`ifdef WRAP_EXT_EN
  logic [EXT_W-1:0] ext;

  assign ext_nxt = ext + EXT_W'(wrap_hit);

  always_ff @(posedge clk) begin
    if (!reset_n) ext <= '0;
    else          ext <= ext_nxt;
  end
`else
  assign ext_nxt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (snap_req) begin
          cap       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (snap_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign snap_valid = (state == HOLD);

  // Capture the post-edge value so a same-edge update is included.
  always_ff @(posedge clk) begin
    if (!reset_n)  snap_data <= '0;
    else if (cap)  snap_data <= {ext_nxt, acc_nxt};
  end

endmodule
